// File: rtl/multi_port_request_unit.sv
// Request sequencer between control and the I/D caches for NUM_DPORTS data ports.
// Optional access timeout enabled by defining REQ_TIMEOUT_EN.
module multi_port_request_unit #(
    parameter int unsigned NUM_DPORTS = 2,
    parameter int unsigned TIMEOUT_W  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  halt,
    input  logic                  regwr,
    input  logic                  ihit,
    input  logic [NUM_DPORTS-1:0] dren,
    input  logic [NUM_DPORTS-1:0] dwen,
    input  logic [NUM_DPORTS-1:0] dhit,
    output logic                  imemREN,
    output logic [NUM_DPORTS-1:0] dmemREN,
    output logic [NUM_DPORTS-1:0] dmemWEN,
    output logic                  wreq,
    output logic                  pcEN,
    output logic                  busy,
    output logic                  timeout
);

    localparam logic [1:0] StFetch  = 2'd0;
    localparam logic [1:0] StData   = 2'd1;
    localparam logic [1:0] StHalted = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [NUM_DPORTS-1:0] pend_r_q, pend_r_d;
    logic [NUM_DPORTS-1:0] pend_w_q, pend_w_d;
    logic                  regwr_q, regwr_d;
    logic                  halt_q, halt_d;

    logic [NUM_DPORTS-1:0] pend;
    logic [NUM_DPORTS-1:0] act_oh;
    logic                  hit_act;
    logic                  last;
    logic                  inst_start;
    logic                  drop;
    logic                  tmo_inst;
    logic                  tmo_flag;

    // Active port is the lowest pending bit, isolated as a one-hot mask.
    assign pend       = pend_r_q | pend_w_q;
    assign act_oh     = pend & (~pend + 1'b1);
    assign hit_act    = |(dhit & act_oh);
    assign last       = ~|(pend & ~act_oh);
    assign inst_start = (state_q == StFetch) & ihit;

`ifdef REQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic                 tmo_q, tmo_d;
    logic                 tmo_inst_q, tmo_inst_d;

    assign cnt_inc  = cnt_q + 1'b1;
    assign drop     = (state_q == StData) & ~hit_act & (&cnt_inc);
    assign tmo_inst = tmo_inst_q;
    assign tmo_flag = tmo_q;

    always_comb begin
        cnt_d      = cnt_q;
        tmo_d      = tmo_q;
        tmo_inst_d = tmo_inst_q;
        if (state_q == StData) begin
            if (hit_act || drop) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_inc;
            end
            if (drop) begin
                tmo_d      = 1'b1;
                tmo_inst_d = 1'b1;
            end
        end
        if (inst_start) begin
            tmo_inst_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
            tmo_inst_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            tmo_inst_q <= tmo_inst_d;
        end
    end
`else
    logic unused_timeout_w;

    assign unused_timeout_w = ^TIMEOUT_W;
    assign drop             = 1'b0;
    assign tmo_inst         = 1'b0;
    assign tmo_flag         = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        pend_r_d = pend_r_q;
        pend_w_d = pend_w_q;
        regwr_d  = regwr_q;
        halt_d   = halt_q;
        imemREN  = 1'b0;
        dmemREN  = '0;
        dmemWEN  = '0;
        wreq     = 1'b0;
        pcEN     = 1'b0;
        busy     = 1'b0;
        timeout  = tmo_flag;

        case (state_q)
            StFetch: begin
                imemREN = 1'b1;
                if (ihit) begin
                    // A port asking for both read and write is serviced as a write.
                    pend_w_d = dwen;
                    pend_r_d = dren & ~dwen;
                    regwr_d  = regwr;
                    halt_d   = halt;
                    if (|(dren | dwen)) begin
                        state_d = StData;
                    end else begin
                        pcEN = ~halt;
                        wreq = regwr & ~halt;
                        if (halt) begin
                            state_d = StHalted;
                        end
                    end
                end
            end
            StData: begin
                busy    = 1'b1;
                dmemREN = pend_r_q & act_oh;
                dmemWEN = pend_w_q & act_oh;
                if (hit_act || drop) begin
                    pend_r_d = pend_r_q & ~act_oh;
                    pend_w_d = pend_w_q & ~act_oh;
                    if (last) begin
                        pcEN    = ~halt_q;
                        wreq    = regwr_q & ~halt_q & ~tmo_inst & ~drop;
                        state_d = halt_q ? StHalted : StFetch;
                    end
                end
            end
            StHalted: begin
            end
            default: begin
                state_d = StFetch;
            end
        endcase

        // Outputs stay quiet while reset is asserted, abandoning any access.
        if (RST) begin
            imemREN = 1'b0;
            dmemREN = '0;
            dmemWEN = '0;
            wreq    = 1'b0;
            pcEN    = 1'b0;
            busy    = 1'b0;
            timeout = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StFetch;
            pend_r_q <= '0;
            pend_w_q <= '0;
            regwr_q  <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_r_q <= pend_r_d;
            pend_w_q <= pend_w_d;
            regwr_q  <= regwr_d;
            halt_q   <= halt_d;
        end
    end

endmodule

// File: doc/multi_port_request_unit.md
Name: multi_port_request_unit

Overview:
- Sequencing block between the control unit and the cache interfaces, generalised to NUM_DPORTS data ports.
- Issues instruction fetches and holds the PC while an instruction's data accesses are outstanding.
- Services the data ports one at a time, lowest index first.
- Gates register write-back and PC advance until every access of the current instruction has completed; parks the core on halt.

Parameters:
NUM_DPORTS, 2, number of independent data-memory ports (1..8)
TIMEOUT_W, 8, width of the per-access wait counter (used only with REQ_TIMEOUT_EN)

Ports:
CLK  in  1  clock, all state updates on rising edge
RST  in  1  reset, synchronous, active-high
halt  in  1  decoded halt of the current instruction
regwr  in  1  current instruction writes the register file
ihit  in  1  instruction cache hit
dren  in  NUM_DPORTS  per-port data read request from control
dwen  in  NUM_DPORTS  per-port data write request from control
dhit  in  NUM_DPORTS  per-port data cache hit
imemREN  out  1  instruction fetch request
dmemREN  out  NUM_DPORTS  per-port data read enable
dmemWEN  out  NUM_DPORTS  per-port data write enable
wreq  out  1  register-file write enable, one-cycle pulse
pcEN  out  1  PC advance, one-cycle pulse
busy  out  1  data phase in progress
timeout  out  1  sticky access-timeout flag

Behaviour:
- State: FSM {FETCH, DATA, HALTED}; pend_r/pend_w masks of NUM_DPORTS bits; active-port index; optional wait counter.
- Reset (RST=1 at edge): state=FETCH, masks=0, counter=0, timeout=0. Every output is 0 during the reset cycle. From the first post-reset cycle, imemREN=1.
- FETCH:
  - imemREN=1; all dmem enables 0.
  - On ihit, latch pend_w=dwen and pend_r=dren&~dwen. A port requesting both is treated as a write.
  - If a mask is nonzero: go to DATA; active port = lowest set bit; pcEN=0, wreq=0.
  - If both masks are 0: pcEN=~halt and wreq=regwr&~halt in the same cycle as ihit; stay in FETCH. If halt=1, go to HALTED.
- DATA:
  - imemREN=0; busy=1.
  - Only the active port k drives an enable: dmemREN[k]=pend_r[k], dmemWEN[k]=pend_w[k].
  - dhit[k] clears pend bit k. The next active port, if any, is driven from the following cycle (one idle cycle between ports is not allowed).
  - dhit on a non-active port is ignored. ihit is ignored.
  - When the last pending bit clears on dhit: in that same cycle pcEN=~halt and wreq=regwr&~halt; next state is FETCH, or HALTED if halt=1.
- HALTED: every output 0 except timeout, which holds its value; only RST exits.
- Latency: an instruction with no memory access advances in 1 cycle (the ihit cycle). An instruction with m accesses takes 1 + sum(hit waits) cycles, with at least one cycle per port.
- Inputs dren/dwen/regwr/halt are sampled at ihit only; changes during DATA have no effect.
- Reset mid-DATA: the pending access is abandoned, no wreq/pcEN pulse, FETCH on the next cycle.

Optional Feature:
REQ_TIMEOUT_EN
- Defined:
  - A TIMEOUT_W-bit counter increments each DATA cycle without dhit on the active port and clears on dhit or port change.
  - When the counter reaches 2**TIMEOUT_W-1, the active port's pending bit is dropped, timeout is set (sticky until RST), and servicing moves to the next port.
  - If any access of the instruction timed out, wreq is suppressed for that instruction; pcEN still pulses.
- Undefined: no counter; waits indefinitely for dhit; timeout tied to 0.

Test Plan:
- RST high 2 cycles, then low -> all outputs 0 during reset; imemREN=1 on first cycle after; no pcEN until ihit.
- ihit with dren=0, dwen=0, regwr=1 -> same cycle pcEN=1, wreq=1; state stays FETCH; 3 back-to-back ihits give 3 pcEN pulses.
- NUM_DPORTS=2; ihit with dren=2'b11, regwr=1:
  - Cycle 1: dmemREN=2'b01.
  - dhit[0] after 3 cycles -> next cycle dmemREN=2'b10.
  - dhit[1] -> pcEN=1 and wreq=1 in that cycle.
  - Stray dhit[1] during the port-0 wait is ignored.
- ihit with dwen[0]=1, dren[0]=1 -> only dmemWEN[0]=1, dmemREN[0]=0; dhit[0] -> pcEN=1, wreq=regwr.
- ihit with halt=1, no access -> pcEN=0, wreq=0, HALTED; subsequent ihit/dhit toggling produce no outputs; RST returns to FETCH.
- REQ_TIMEOUT_EN, TIMEOUT_W=3, dren=2'b01, dhit never -> after 7 DATA cycles timeout=1, pcEN=1, wreq=0; timeout remains 1 until RST.
